// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared mode encodings for the arbitrating mux
package arb_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// rr_arbiter: round-robin search from ptr with wrap, ptr advances past each served channel
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic              grant_vld,
  output logic [SEL_W-1:0]  grant_idx
);
  logic [SEL_W-1:0] ptr;
  int idx;
  // descending scan so the lowest offset from ptr wins
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx = 0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance) ptr <= grant_idx == SEL_W'(NUM_IN - 1) ? '0 : grant_idx + 1'b1;
  end
endmodule

// File: rtl/arb_mux.sv
// arb_mux: fixed/round-robin channel arbiter feeding a single registered output entry
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);
  localparam int PADW = 2 ** SEL_W;
  logic             rr_vld, gvld, can_accept, xfer;
  logic [SEL_W-1:0] rr_idx, gidx;
  logic [PADW-1:0]  vld_pad;
  rr_arbiter #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_rr (
    .clk(clk),
    .rst(rst),
    .req(in_valid),
    .advance(xfer && mode == MODE_RR),
    .grant_vld(rr_vld),
    .grant_idx(rr_idx)
  );
  // padding makes out-of-range sel read as an idle channel
  always_comb begin
    vld_pad    = PADW'(in_valid);
    can_accept = !out_valid || out_ready;
    gvld       = mode == MODE_RR ? rr_vld : vld_pad[sel];
    gidx       = mode == MODE_RR ? rr_idx : sel;
    in_ready   = (gvld && can_accept && !rst) ? {{(NUM_IN-1){1'b0}}, 1'b1} << gidx : '0;
    xfer       = |(in_valid & in_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gidx*WIDTH +: WIDTH];
      out_src   <= gidx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed checks of fixed/round-robin arbitration, backpressure and reset
module tb_arb_mux;
  logic        clk = 0, rst = 1;
  logic [31:0] in_data = '0;
  logic [7:0]  in_valid = '0, in_ready;
  logic        mode = 1'b1, out_ready = 1'b0, out_valid;
  logic [2:0]  sel = '0, out_src;
  logic [3:0]  out_data;
  logic [23:0] d6 = 24'h543210;
  logic [5:0]  v6 = '0, r6;
  logic        m6 = 1'b0, or6 = 1'b1, ov6;
  logic [2:0]  s6 = 3'd3, src6;
  logic [3:0]  od6;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  arb_mux dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_src(out_src)
  );
  arb_mux #(.WIDTH(4), .NUM_IN(6)) dut6 (
    .clk(clk), .rst(rst), .in_data(d6), .in_valid(v6), .in_ready(r6),
    .mode(m6), .sel(s6), .out_data(od6), .out_valid(ov6),
    .out_ready(or6), .out_src(src6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    in_valid = 8'hFF;
    v6 = 6'h3F;
    step();
    step();
    chk("rst_ready", 32'(in_ready), 32'h00);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_src", 32'(out_src), 32'h0);
    chk("rst_ready6", 32'(r6), 32'h00);
    // fixed sel=3
    rst = 0;
    mode = 1'b0; sel = 3'd3; in_data = 32'h7654A210; out_ready = 1'b1;
    #1;
    chk("fix_ready0", 32'(in_ready), 32'h08);
    chk("n6_ready0", 32'(r6), 32'h08);
    step();
    chk("fix_valid", 32'(out_valid), 32'h1);
    chk("fix_data", 32'(out_data), 32'hA);
    chk("fix_src", 32'(out_src), 32'h3);
    chk("fix_ready1", 32'(in_ready), 32'h08);
    chk("n6_src", 32'(src6), 32'h3);
    chk("n6_data", 32'(od6), 32'h3);
    // NUM_IN=6 with sel past the last channel
    s6 = 3'd7;
    #1;
    chk("n6_ready_oor", 32'(r6), 32'h00);
    step();
    chk("n6_drain", 32'(ov6), 32'h0);
    step();
    chk("n6_idle", 32'(ov6), 32'h0);
    chk("n6_ready_oor2", 32'(r6), 32'h00);
    // round robin, all valid
    mode = 1'b1; in_data = 32'h76543210;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_src", 32'(out_src), 32'(i % 8));
      chk("rr_data", 32'(out_data), 32'(i % 8));
    end
    // ptr is 1: move it to 2, then sparse request pattern
    in_valid = 8'h02;
    step();
    chk("rr_p2", 32'(out_src), 32'h1);
    in_valid = 8'b1000_0010;
    step();
    chk("rr_wrap7", 32'(out_src), 32'h7);
    step();
    chk("rr_wrap1", 32'(out_src), 32'h1);
    in_valid = 8'h86;
    step();
    chk("rr_ptr2", 32'(out_src), 32'h2);
    // drain then backpressure
    in_valid = 8'h00;
    step();
    chk("drain", 32'(out_valid), 32'h0);
    mode = 1'b0; sel = 3'd5; in_valid = 8'h20;
    step();
    chk("bp_load", 32'(out_data), 32'h5);
    out_ready = 1'b0; in_valid = 8'hFF; sel = 3'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'h00);
      step();
      chk("bp_data", 32'(out_data), 32'h5);
      chk("bp_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(in_ready), 32'h04);
    step();
    chk("bp_rel_data", 32'(out_data), 32'h2);
    chk("bp_rel_src", 32'(out_src), 32'h2);
    chk("bp_rel_valid", 32'(out_valid), 32'h1);
    // sel change does not disturb a held word
    out_ready = 1'b0; sel = 3'd6;
    step();
    chk("held_data", 32'(out_data), 32'h2);
    chk("held_src", 32'(out_src), 32'h2);
    // ptr is 3: grant 4 moves it to 5, then reset mid-operation
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'h10;
    step();
    chk("pre_rst_src", 32'(out_src), 32'h4);
    rst = 1; in_valid = 8'hFF;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'h00);
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data", 32'(out_data), 32'h0);
    chk("mid_rst_src", 32'(out_src), 32'h0);
    rst = 0;
    step();
    chk("post_rst_src", 32'(out_src), 32'h0);
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    step();
    chk("post_rst_next", 32'(out_src), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel.
REQ-002 Parameter NUM_IN, default 8, number of input channels (2..16).
REQ-003 Parameter SEL_W, default $clog2(NUM_IN), derived width of select/source fields; never overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  NUM_IN*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  per-channel valid.
REQ-008 in_ready  output  NUM_IN  per-channel ready; transfer on channel i when in_valid[i] and in_ready[i] are both high.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SEL_W  channel index used in fixed mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accepts; transfer when out_valid and out_ready are both high.
REQ-014 out_src  output  SEL_W  index of the channel that supplied out_data.

Function
REQ-015 Output stage SHALL be a single registered entry; can_accept = !out_valid | out_ready.
REQ-016 At most one in_ready bit SHALL be high per cycle, and only for the granted channel while can_accept is high.
REQ-017 Fixed mode SHALL grant channel sel when in_valid[sel] is high; no other channel is granted.
REQ-018 Fixed mode with sel >= NUM_IN SHALL grant nothing, and all in_ready bits SHALL stay low.
REQ-019 Round-robin mode SHALL grant the first valid channel found searching upward from pointer ptr, wrapping from NUM_IN-1 to 0.
REQ-020 After a round-robin input transfer on channel g, ptr SHALL become g+1, or 0 when g = NUM_IN-1.
REQ-021 ptr SHALL NOT change on cycles without an input transfer, or in fixed mode.
REQ-022 Latency from input transfer to out_valid high SHALL be exactly 1 cycle.
REQ-023 On an input transfer, out_data and out_src SHALL load the granted channel's data and index on the same edge.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_src SHALL remain stable and no input transfer SHALL occur.
REQ-025 Simultaneous output drain and input transfer SHALL load the new word, keep out_valid=1, and give zero bubble cycles (full throughput).
REQ-026 Output drain with no input transfer SHALL clear out_valid on the next edge.
REQ-027 mode and sel changes SHALL affect only grants computed after the change; a word already held is unaffected.
REQ-028 Grant logic SHALL be combinational from in_valid, mode, sel, ptr and can_accept; in_ready SHALL NOT depend combinationally on in_data.

Reset
REQ-029 While rst=1 at a clock edge: out_valid=0, out_data=0, out_src=0, ptr=0.
REQ-030 in_ready SHALL be all-zero in any cycle where rst=1.
REQ-031 Reset mid-operation SHALL discard the held word without completing its output transfer; no input transfer occurs that cycle.

Structure
REQ-032 Package arb_mux_pkg SHALL hold the MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
REQ-033 Round-robin search plus ptr register SHALL live in sub-module rr_arbiter, parametrised by NUM_IN, with outputs grant_vld and grant_idx.
REQ-034 Fixed/RR grant selection, output register and handshake SHALL live in arb_mux.

Verification (WIDTH=4, NUM_IN=8 unless stated)
REQ-035 Fixed mode, sel=3, in_valid=8'hFF, ch3 data=4'hA, out_ready=1: next cycle out_data=4'hA and out_src=3; in_ready=8'h08 every cycle.
REQ-036 RR mode, all valid, ch i data=i, out_ready=1: out_src sequence 0,1,...,7,0 on consecutive cycles, no bubbles.
REQ-037 RR mode, in_valid=8'b1000_0010, ptr=2: grants 7 then 1, then ptr=2.
REQ-038 Backpressure: out_valid=1 holding 4'h5, out_ready=0 for 4 cycles: out_data stays 4'h5, in_ready=0; out_ready=1 then loads the next word the same edge.
REQ-039 Fixed mode, sel=3, NUM_IN=6, then sel=7: no grants, in_ready=0, out_valid clears after drain.
REQ-040 rst=1 asserted while out_valid=1 and ptr=5: next cycle out_valid=0, out_data=0, out_src=0; first RR grant after release starts at channel 0.
